mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory request arbiter in front of a single mem-to-AXI bridge.
// One transaction in flight at a time: a winner is picked in IDLE, its
// payload is latched and presented downstream until the bridge grants.
// Completion pulses are routed back combinationally to the owning port.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  s0_req_i,
    input  logic [ADDR_WIDTH-1:0] s0_addr_i,
    input  logic                  s0_we_i,
    input  logic [BE_WIDTH-1:0]   s0_be_i,
    input  logic [DATA_WIDTH-1:0] s0_wdata_i,
    output logic                  s0_gnt_o,
    output logic                  s0_rvalid_o,
    output logic [DATA_WIDTH-1:0] s0_rdata_o,

    input  logic                  s1_req_i,
    input  logic [ADDR_WIDTH-1:0] s1_addr_i,
    input  logic                  s1_we_i,
    input  logic [BE_WIDTH-1:0]   s1_be_i,
    input  logic [DATA_WIDTH-1:0] s1_wdata_i,
    output logic                  s1_gnt_o,
    output logic                  s1_rvalid_o,
    output logic [DATA_WIDTH-1:0] s1_rdata_o,

    output logic                  dn_req_o,
    output logic [ADDR_WIDTH-1:0] dn_addr_o,
    output logic                  dn_we_o,
    output logic [BE_WIDTH-1:0]   dn_be_o,
    output logic [DATA_WIDTH-1:0] dn_wdata_o,
    input  logic                  dn_gnt_i,
    input  logic                  dn_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dn_rdata_i,

    output logic                  busy_o,
    output logic                  owner_o
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t state_q, state_d;
    logic   owner_q;
    logic   last_grant_q;
    logic   winner;
    logic   load;
    logic   done;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Winner selection; only meaningful when at least one port requests.
    // Round-robin favours the port that did not complete last.
    always_comb begin
        winner = 1'b0;
        if (FIXED_PRIO != 0)
            winner = ~s0_req_i;
        else if (s0_req_i && s1_req_i)
            winner = ~last_grant_q;
        else
            winner = s1_req_i;
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; grants seen in IDLE fall through untouched.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_req_i || s1_req_i) begin
                    state_d = ISSUE;
                    load    = 1'b1;
                end
            end
            ISSUE: begin
                if (dn_gnt_i) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload and owner latch at arbitration; held constant through ISSUE.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
        end else if (load) begin
            addr_q  <= winner ? s1_addr_i  : s0_addr_i;
            we_q    <= winner ? s1_we_i    : s0_we_i;
            be_q    <= winner ? s1_be_i    : s0_be_i;
            wdata_q <= winner ? s1_wdata_i : s0_wdata_i;
            owner_q <= winner;
        end
    end

    // Remember who completed last, for round-robin fairness.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)   last_grant_q <= 1'b1;
        else if (done) last_grant_q <= owner_q;
    end

    assign dn_req_o   = (state_q == ISSUE);
    assign busy_o     = (state_q == ISSUE);
    assign owner_o    = owner_q;
    assign dn_addr_o  = addr_q;
    assign dn_we_o    = we_q;
    assign dn_be_o    = be_q;
    assign dn_wdata_o = wdata_q;

    assign s0_gnt_o    = dn_gnt_i    && (state_q == ISSUE) && !owner_q;
    assign s1_gnt_o    = dn_gnt_i    && (state_q == ISSUE) &&  owner_q;
    assign s0_rvalid_o = dn_rvalid_i && (state_q == ISSUE) && !owner_q;
    assign s1_rvalid_o = dn_rvalid_i && (state_q == ISSUE) &&  owner_q;
    assign s0_rdata_o  = dn_rdata_i;
    assign s1_rdata_o  = dn_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 round-robin, instance 1 fixed
// priority. A transaction-level reference model is compared every cycle,
// alongside a vector table and directed corner-case sequences.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk_i = 1'b0;
    logic rst   = 1'b1;
    always #5 clk_i = ~clk_i;

    logic          req   [2][2];
    logic [AW-1:0] addr  [2][2];
    logic          we    [2][2];
    logic [BW-1:0] be    [2][2];
    logic [DW-1:0] wd    [2][2];
    logic          gnt   [2][2];
    logic          rv    [2][2];
    logic [DW-1:0] rd    [2][2];
    logic          dn_req[2];
    logic [AW-1:0] dn_addr[2];
    logic          dn_we [2];
    logic [BW-1:0] dn_be [2];
    logic [DW-1:0] dn_wd [2];
    logic          dn_gnt[2];
    logic          dn_rv [2];
    logic [DW-1:0] dn_rd [2];
    logic          busy  [2];
    logic          owner [2];

    for (genvar K = 0; K < 2; K++) begin : g_dut
        mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
                           .FIXED_PRIO(K)) u_dut (
            .clk_i(clk_i), .reset_i(rst),
            .s0_req_i(req[K][0]), .s0_addr_i(addr[K][0]), .s0_we_i(we[K][0]),
            .s0_be_i(be[K][0]), .s0_wdata_i(wd[K][0]),
            .s0_gnt_o(gnt[K][0]), .s0_rvalid_o(rv[K][0]), .s0_rdata_o(rd[K][0]),
            .s1_req_i(req[K][1]), .s1_addr_i(addr[K][1]), .s1_we_i(we[K][1]),
            .s1_be_i(be[K][1]), .s1_wdata_i(wd[K][1]),
            .s1_gnt_o(gnt[K][1]), .s1_rvalid_o(rv[K][1]), .s1_rdata_o(rd[K][1]),
            .dn_req_o(dn_req[K]), .dn_addr_o(dn_addr[K]), .dn_we_o(dn_we[K]),
            .dn_be_o(dn_be[K]), .dn_wdata_o(dn_wd[K]),
            .dn_gnt_i(dn_gnt[K]), .dn_rvalid_i(dn_rv[K]), .dn_rdata_i(dn_rd[K]),
            .busy_o(busy[K]), .owner_o(owner[K])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic          m_busy[2];
    logic          m_own [2];
    logic          m_last[2];
    logic [AW-1:0] m_addr[2];
    logic          m_we  [2];
    logic [BW-1:0] m_be  [2];
    logic [DW-1:0] m_wd  [2];

    // Who gets served when the arbiter is free: port 0 under fixed priority,
    // the lone requester, or else whichever port did not complete last.
    function automatic int pick(int k, logic r0, logic r1, logic last);
        if (k == 1 && r0) return 0;
        if (r0 && r1)     return last ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    // Model advances one transaction step per clock.
    always @(posedge clk_i or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0; m_own[k] <= 1'b0; m_last[k] <= 1'b1;
                m_addr[k] <= '0;   m_we[k]  <= 1'b0; m_be[k]   <= '0; m_wd[k] <= '0;
            end else if (!m_busy[k]) begin
                if (req[k][0] || req[k][1]) begin
                    m_busy[k] <= 1'b1;
                    m_own[k]  <= pick(k, req[k][0], req[k][1], m_last[k]) == 1;
                    m_addr[k] <= addr[k][pick(k, req[k][0], req[k][1], m_last[k])];
                    m_we[k]   <= we  [k][pick(k, req[k][0], req[k][1], m_last[k])];
                    m_be[k]   <= be  [k][pick(k, req[k][0], req[k][1], m_last[k])];
                    m_wd[k]   <= wd  [k][pick(k, req[k][0], req[k][1], m_last[k])];
                end
            end else if (dn_gnt[k]) begin
                m_busy[k] <= 1'b0;
                m_last[k] <= m_own[k];
            end
        end
    end

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = $sformatf("d%0d.", k);
            chk({p, "dn_req"},   dn_req[k],  m_busy[k]);
            chk({p, "busy"},     busy[k],    m_busy[k]);
            chk({p, "owner"},    owner[k],   m_own[k]);
            chk({p, "dn_addr"},  dn_addr[k], m_addr[k]);
            chk({p, "dn_we"},    dn_we[k],   m_we[k]);
            chk({p, "dn_be"},    dn_be[k],   m_be[k]);
            chk({p, "dn_wdata"}, dn_wd[k],   m_wd[k]);
            for (int n = 0; n < 2; n++) begin
                chk($sformatf("%ss%0d_gnt", p, n), gnt[k][n],
                    m_busy[k] && dn_gnt[k] && (m_own[k] == n[0]));
                chk($sformatf("%ss%0d_rvalid", p, n), rv[k][n],
                    m_busy[k] && dn_rv[k] && (m_own[k] == n[0]));
                chk($sformatf("%ss%0d_rdata", p, n), rd[k][n], dn_rd[k]);
            end
        end
    endtask

    // One clock: model comparison at the falling edge, then land 1 time
    // unit after the next rising edge, where stimulus is changed.
    task automatic cyc();
        @(negedge clk_i);
        model_check();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 2; n++) begin
                req[k][n] = 1'b0; addr[k][n] = '0; we[k][n] = 1'b0;
                be[k][n] = '0; wd[k][n] = '0;
            end
            dn_gnt[k] = 1'b0; dn_rv[k] = 1'b0; dn_rd[k] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d.rst_dn_req", k), dn_req[k], 1'b0);
            chk($sformatf("d%0d.rst_busy", k),   busy[k],   1'b0);
            chk($sformatf("d%0d.rst_owner", k),  owner[k],  1'b0);
            chk($sformatf("d%0d.rst_addr", k),   dn_addr[k], '0);
        end
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Wait for dn_req, hold the grant back for lat cycles, pulse it, and
    // confirm the idle gap that follows.
    task automatic serve(input int k, input int lat, output int own);
        int t;
        t = 0;
        while (!dn_req[k] && t < 20) begin cyc(); t++; end
        chk($sformatf("d%0d.serve_req", k), dn_req[k], 1'b1);
        for (int i = 1; i < lat; i++) cyc();
        dn_gnt[k] = 1'b1; dn_rv[k] = 1'b1; dn_rd[k] = $urandom;
        own = int'(owner[k]);
        cyc();
        dn_gnt[k] = 1'b0; dn_rv[k] = 1'b0;
        #1;
        chk($sformatf("d%0d.idle_gap", k), dn_req[k], 1'b0);
    endtask

    typedef struct {
        logic          r0, r1, g;
        logic          e_req, e_own, e_g0, e_g1;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl[11];
    int   own;
    int   nhigh;
    logic gs[2][2];
    logic rs[2];
    int   cnt[2];

    initial begin
        clear_inputs();
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200};

        // Vector table on the round-robin instance.
        do_reset();
        addr[0][0] = 32'h100; addr[0][1] = 32'h200; be[0][0] = 4'hF; be[0][1] = 4'hF;
        for (int i = 0; i < 11; i++) begin
            req[0][0] = tbl[i].r0; req[0][1] = tbl[i].r1;
            dn_gnt[0] = tbl[i].g;  dn_rv[0]  = tbl[i].g;
            #1;
            chk($sformatf("tbl%0d.dn_req", i), dn_req[0], tbl[i].e_req);
            chk($sformatf("tbl%0d.owner", i),  owner[0],  tbl[i].e_own);
            chk($sformatf("tbl%0d.s0_gnt", i), gnt[0][0], tbl[i].e_g0);
            chk($sformatf("tbl%0d.s1_gnt", i), gnt[0][1], tbl[i].e_g1);
            chk($sformatf("tbl%0d.s0_rv", i),  rv[0][0],  tbl[i].e_g0);
            chk($sformatf("tbl%0d.s1_rv", i),  rv[0][1],  tbl[i].e_g1);
            chk($sformatf("tbl%0d.dn_addr", i), dn_addr[0], tbl[i].e_addr);
            cyc();
        end

        // s0 read with a three-cycle downstream latency.
        do_reset();
        req[0][0] = 1'b1; addr[0][0] = 32'h100;
        #1;
        chk("rd.pre_req", dn_req[0], 1'b0);
        cyc();
        nhigh = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin dn_gnt[0] = 1'b1; dn_rv[0] = 1'b1; dn_rd[0] = 32'hDEADBEEF; end
            #1;
            if (dn_req[0]) nhigh++;
            if (i == 2) begin
                chk("rd.s0_gnt", gnt[0][0], 1'b1);
                chk("rd.s0_rvalid", rv[0][0], 1'b1);
                chk("rd.s0_rdata", rd[0][0], 32'hDEADBEEF);
                chk("rd.s1_gnt", gnt[0][1], 1'b0);
                chk("rd.s1_rvalid", rv[0][1], 1'b0);
            end else begin
                chk("rd.s0_gnt_early", gnt[0][0], 1'b0);
            end
            cyc();
        end
        dn_gnt[0] = 1'b0; dn_rv[0] = 1'b0; req[0][0] = 1'b0;
        #1;
        chk("rd.post_req", dn_req[0], 1'b0);
        chk("rd.req_cycles", nhigh, 3);
        cyc();

        // Continuous requesters, round-robin: 0,1,0,1.
        do_reset();
        req[0][0] = 1'b1; req[0][1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(0, 1 + i % 3, own);
            chk($sformatf("rr.order%0d", i), own, i % 2);
        end
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        cyc();

        // Continuous requesters, fixed priority: s1 only after s0 drops.
        do_reset();
        req[1][0] = 1'b1; req[1][1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve(1, 2, own);
            chk($sformatf("fp.order%0d", i), own, 0);
        end
        req[1][0] = 1'b0;
        serve(1, 1, own);
        chk("fp.s1_after_drop", own, 1);
        req[1][1] = 1'b0;
        cyc();

        // s1 write; s0 arrives mid-ISSUE and must wait.
        do_reset();
        req[0][1] = 1'b1; addr[0][1] = 32'h20; we[0][1] = 1'b1; be[0][1] = 4'h3;
        wd[0][1] = 32'h1234;
        cyc();
        req[0][0] = 1'b1; addr[0][0] = 32'h999; we[0][0] = 1'b0; be[0][0] = 4'hF;
        wd[0][0] = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin dn_gnt[0] = 1'b1; dn_rv[0] = 1'b1; end
            #1;
            chk($sformatf("wr.addr%0d", i), dn_addr[0], 32'h20);
            chk($sformatf("wr.be%0d", i), dn_be[0], 4'h3);
            chk($sformatf("wr.wdata%0d", i), dn_wd[0], 32'h1234);
            chk($sformatf("wr.we%0d", i), dn_we[0], 1'b1);
            chk($sformatf("wr.owner%0d", i), owner[0], 1'b1);
            cyc();
        end
        dn_gnt[0] = 1'b0; dn_rv[0] = 1'b0; req[0][1] = 1'b0;
        #1;
        chk("wr.gap", dn_req[0], 1'b0);
        cyc();
        chk("wr.s0_req", dn_req[0], 1'b1);
        chk("wr.s0_owner", owner[0], 1'b0);
        chk("wr.s0_addr", dn_addr[0], 32'h999);
        dn_gnt[0] = 1'b1; dn_rv[0] = 1'b1;
        cyc();
        dn_gnt[0] = 1'b0; dn_rv[0] = 1'b0; req[0][0] = 1'b0;
        cyc();

        // Reset during ISSUE aborts with no grant pulse.
        do_reset();
        req[0][0] = 1'b1; addr[0][0] = 32'h40;
        cyc();
        chk("ra.busy_before", busy[0], 1'b1);
        cyc();
        rst = 1'b1; dn_gnt[0] = 1'b1; dn_rv[0] = 1'b1;
        #1;
        chk("ra.dn_req", dn_req[0], 1'b0);
        chk("ra.busy", busy[0], 1'b0);
        chk("ra.s0_gnt", gnt[0][0], 1'b0);
        chk("ra.s0_rvalid", rv[0][0], 1'b0);
        cyc();
        rst = 1'b0; dn_gnt[0] = 1'b0; dn_rv[0] = 1'b0;
        serve(0, 2, own);
        chk("ra.next_owner", own, 0);
        req[0][0] = 1'b0;
        cyc();

        // Grant arriving while IDLE is ignored.
        do_reset();
        dn_gnt[0] = 1'b1; dn_rv[0] = 1'b1;
        #1;
        chk("ig.s0_gnt", gnt[0][0], 1'b0);
        chk("ig.s1_gnt", gnt[0][1], 1'b0);
        chk("ig.busy", busy[0], 1'b0);
        cyc();
        dn_gnt[0] = 1'b0; dn_rv[0] = 1'b0;
        #1;
        chk("ig.busy_after", busy[0], 1'b0);
        cyc();

        // Random traffic against the model on both instances.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            rs[k] = 1'b0; cnt[k] = 0;
            gs[k][0] = 1'b0; gs[k][1] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                for (int n = 0; n < 2; n++) begin
                    if ((req[k][n] && gs[k][n]) || (!req[k][n] && $urandom_range(2) == 0)) begin
                        req[k][n]  = req[k][n] ? 1'($urandom_range(1)) : 1'b1;
                        addr[k][n] = $urandom;
                        we[k][n]   = 1'($urandom_range(1));
                        be[k][n]   = 4'($urandom_range(15));
                        wd[k][n]   = $urandom;
                    end
                end
                if (dn_gnt[k]) begin
                    dn_gnt[k] = 1'b0;
                end else if (rs[k]) begin
                    if (cnt[k] == 0) dn_gnt[k] = 1'b1;
                    else             cnt[k]--;
                end else begin
                    cnt[k]    = $urandom_range(3);
                    dn_gnt[k] = ($urandom_range(15) == 0);
                end
                dn_rv[k] = dn_gnt[k];
                dn_rd[k] = $urandom;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                rs[k] = dn_req[k];
                gs[k][0] = gnt[k][0];
                gs[k][1] = gnt[k][1];
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
